// File: rtl/fixed_point_muldiv_unit.sv
// fixed_point_muldiv_unit
//
// Iterative radix-2 multiply/divide coprocessor. It sits beside the alu: the
// controller pulses start, waits for done, then writes result/aux back
// through the register-file write-data mux. Only one operation is in flight
// at a time, and operands are captured on the accepting edge.
//
// Operations:
//   00 signed fixed-point multiply (Q(WIDTH-FRAC_BITS).FRAC_BITS, floor, saturating)
//   01 unsigned integer multiply   (result = low half, aux = high half)
//   10 signed fixed-point divide   (truncate toward zero, saturating)
//   11 unsigned integer divide     (result = quotient, aux = remainder)
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   start          request, sampled only while not iterating
//   operation      operation select (see above)
//   operand_a      multiplicand / dividend
//   operand_b      multiplier / divisor
//   busy           high while iterating
//   done           one-cycle pulse; result, aux and flags valid from this cycle
//   result         product / quotient
//   aux            upper product half (op 01), remainder (op 11), else 0
//   overflow       result saturated or truncated
//   divide_by_zero divisor was zero (divide operations only)
//   zero           result == 0
//   negative       result MSB
module fixed_point_muldiv_unit #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       operation,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] aux,
  output logic             overflow,
  output logic             divide_by_zero,
  output logic             zero,
  output logic             negative
);

  localparam int QW    = WIDTH + FRAC_BITS;
  localparam int CNT_W = $clog2(QW + 1);

  localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FDIV_LAST = CNT_W'(QW - 1);

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Largest quotient magnitudes that still fit a signed WIDTH result.
  localparam logic [QW-1:0] POS_LIM = {{(FRAC_BITS+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [QW-1:0] NEG_LIM = {{FRAC_BITS{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which is representable as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Saturate an already-shifted signed product to WIDTH bits.
  // Returns {overflow, value}. The value fits when the upper WIDTH+1 bits
  // are all copies of the sign.
  function automatic logic [WIDTH:0] sat_fixed_mul(input logic signed [2*WIDTH-1:0] shifted);
    if ((&shifted[2*WIDTH-1:WIDTH-1]) || !(|shifted[2*WIDTH-1:WIDTH-1]))
      return {1'b0, shifted[WIDTH-1:0]};
    else if (shifted[2*WIDTH-1])
      return {1'b1, MIN_NEG};
    else
      return {1'b1, MAX_POS};
  endfunction

  // Apply the sign to an unsigned quotient magnitude and saturate.
  // Returns {overflow, value}.
  function automatic logic [WIDTH:0] sat_fixed_div(input logic [QW-1:0] mag,
                                                   input logic          neg);
    if (!neg) begin
      if (mag > POS_LIM)
        return {1'b1, MAX_POS};
      return {1'b0, mag[WIDTH-1:0]};
    end
    if (mag > NEG_LIM)
      return {1'b1, MIN_NEG};
    return {1'b0, -mag[WIDTH-1:0]};
  endfunction

  state_t           state;
  logic [CNT_W-1:0] iter_cnt;
  logic [CNT_W-1:0] last_cnt;
  logic [1:0]       op_q;
  logic             neg_q;

  // Multiplier: {hi_q, lo_q} shifts right one bit per cycle while the
  // multiplier bits in lo_q are consumed from the LSB.
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Divider: quo_q starts holding the left-aligned dividend and fills with
  // quotient bits from the LSB as dividend bits leave from the MSB.
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [QW-1:0]    quo_q;

  logic             accept;
  logic             div_zero_req;
  logic             signed_op;
  logic [WIDTH-1:0] load_a;
  logic [WIDTH-1:0] load_b;
  logic [WIDTH-1:0] dz_result;
  logic [WIDTH-1:0] dz_aux;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] nx_hi;
  logic [WIDTH-1:0] nx_lo;
  logic [WIDTH-1:0] nx_rem;
  logic [QW-1:0]    nx_quo;
  logic             unused_bits;

  logic [2*WIDTH-1:0]        prod_mag;
  logic signed [2*WIDTH-1:0] prod_signed;
  logic signed [2*WIDTH-1:0] prod_shifted;
  logic [WIDTH:0]            mul_sat;
  logic [WIDTH:0]            div_sat;
  logic [WIDTH-1:0]          fin_result;
  logic [WIDTH-1:0]          fin_aux;
  logic                      fin_ovf;

  assign accept       = start && (state != RUN);
  assign div_zero_req = operation[1] && (operand_b == '0);
  assign signed_op    = !operation[0];
  assign load_a       = signed_op ? magnitude(operand_a) : operand_a;
  assign load_b       = signed_op ? magnitude(operand_b) : operand_b;
  assign last_cnt     = (op_q == 2'b10) ? FDIV_LAST : MUL_LAST;

  assign dz_result = operation[0] ? '1 : (operand_a[WIDTH-1] ? MIN_NEG : MAX_POS);
  assign dz_aux    = operation[0] ? operand_a : '0;

  // One radix-2 step of each engine; both advance every RUN cycle and the
  // operation code selects which one is read out.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    nx_hi     = mul_sum[WIDTH:1];
    nx_lo     = {mul_sum[0], lo_q[WIDTH-1:1]};
    div_trial = {rem_q, quo_q[QW-1]};
    div_diff  = div_trial - {1'b0, divisor_q};
    div_ge    = (div_trial >= {1'b0, divisor_q});
    nx_rem    = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    nx_quo    = {quo_q[QW-2:0], div_ge};
  end

  // After a successful subtract the difference is below the divisor, so its
  // top bit is always clear.
  assign unused_bits = div_diff[WIDTH];

  // Result formatting works on the post-step values so the last iteration
  // and the DONE write happen on the same edge.
  always_comb begin
    prod_mag     = {nx_hi, nx_lo};
    prod_signed  = neg_q ? -$signed(prod_mag) : $signed(prod_mag);
    prod_shifted = prod_signed >>> FRAC_BITS;
    mul_sat      = sat_fixed_mul(prod_shifted);
    div_sat      = sat_fixed_div(nx_quo, neg_q);
    fin_result   = '0;
    fin_aux      = '0;
    fin_ovf      = 1'b0;
    case (op_q)
      2'b00: begin
        fin_result = mul_sat[WIDTH-1:0];
        fin_ovf    = mul_sat[WIDTH];
      end
      2'b01: begin
        fin_result = nx_lo;
        fin_aux    = nx_hi;
        fin_ovf    = |nx_hi;
      end
      2'b10: begin
        fin_result = div_sat[WIDTH-1:0];
        fin_ovf    = div_sat[WIDTH];
      end
      default: begin
        fin_result = nx_quo[WIDTH-1:0];
        fin_aux    = nx_rem;
      end
    endcase
  end

  // Operand capture and iteration registers.
  always_ff @(posedge clock) begin
    if (accept) begin
      mcand_q   <= load_a;
      lo_q      <= load_b;
      hi_q      <= '0;
      divisor_q <= load_b;
      rem_q     <= '0;
      quo_q     <= {load_a, {FRAC_BITS{1'b0}}};
      neg_q     <= signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
    end else if (busy) begin
      hi_q  <= nx_hi;
      lo_q  <= nx_lo;
      rem_q <= nx_rem;
      quo_q <= nx_quo;
    end
  end

  // Control FSM and architectural outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      iter_cnt       <= '0;
      op_q           <= 2'b00;
      busy           <= 1'b0;
      done           <= 1'b0;
      result         <= '0;
      aux            <= '0;
      overflow       <= 1'b0;
      divide_by_zero <= 1'b0;
      zero           <= 1'b0;
      negative       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            op_q     <= operation;
            iter_cnt <= '0;
            if (div_zero_req) begin
              // Nothing to iterate: report straight away.
              state          <= DONE;
              done           <= 1'b1;
              result         <= dz_result;
              aux            <= dz_aux;
              overflow       <= 1'b1;
              divide_by_zero <= 1'b1;
              zero           <= (dz_result == '0);
              negative       <= dz_result[WIDTH-1];
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (iter_cnt == last_cnt) begin
            state          <= DONE;
            busy           <= 1'b0;
            done           <= 1'b1;
            result         <= fin_result;
            aux            <= fin_aux;
            overflow       <= fin_ovf;
            divide_by_zero <= 1'b0;
            zero           <= (fin_result == '0);
            negative       <= fin_result[WIDTH-1];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_muldiv_unit.sv
module tb_fixed_point_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  operation;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [15:0] aux;
  logic        overflow;
  logic        divide_by_zero;
  logic        zero;
  logic        negative;

  int checks   = 0;
  int failures = 0;
  int lat;
  int busy_cycles;

  always #5 clock = ~clock;

  fixed_point_muldiv_unit #(.WIDTH(16), .FRAC_BITS(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .operation      (operation),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .aux            (aux),
    .overflow       (overflow),
    .divide_by_zero (divide_by_zero),
    .zero           (zero),
    .negative       (negative)
  );

  // Counts cycles (sampled on falling edges) from the accepting edge until
  // done; cycle 1 is the one right after the accepting edge.
  task automatic wait_done();
    bit seen;
    seen        = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    while (!seen && lat < 200) begin
      @(negedge clock);
      lat++;
      if (done) seen = 1'b1;
      else if (busy) busy_cycles++;
    end
    if (!seen) $display("FAIL wait_done timeout after %0d cycles", lat);
  endtask

  // Issue one operation, scramble the operand inputs after acceptance,
  // and return at the falling edge of the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clock);
    operation = op;
    operand_a = a;
    operand_b = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    operation = ~op;
    operand_a = 16'hA5A5;
    operand_b = 16'h5A5A;
    wait_done();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    start     = 1'b0;
    operation = 2'b00;
    operand_a = 16'h0000;
    operand_b = 16'h0000;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h exp=0000", result); end
    checks++; if (aux !== 16'h0000) begin failures++; $display("FAIL reset_aux got=%h exp=0000", aux); end
    checks++; if ({overflow, divide_by_zero, zero, negative} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {overflow, divide_by_zero, zero, negative});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL reset_idle got=%b exp=00", {busy, done}); end
  endtask

  task automatic test_signed_fixed_mul();
    run_op(2'b00, 16'h0180, 16'hFE00);  // 1.5 * -2.0
    checks++; if (lat !== 17) begin failures++; $display("FAIL fmul_latency got=%0d exp=17", lat); end
    checks++; if (busy_cycles !== 16) begin failures++; $display("FAIL fmul_busy got=%0d exp=16", busy_cycles); end
    checks++; if (result !== 16'hFD00) begin failures++; $display("FAIL fmul_result got=%h exp=FD00", result); end
    checks++; if ({negative, overflow, zero, divide_by_zero} !== 4'b1000) begin
      failures++; $display("FAIL fmul_flags got=%b exp=1000", {negative, overflow, zero, divide_by_zero});
    end
    checks++; if (aux !== 16'h0000) begin failures++; $display("FAIL fmul_aux got=%h exp=0000", aux); end

    run_op(2'b00, 16'h7F00, 16'h0200);  // 127.0 * 2.0 -> positive saturation
    checks++; if (result !== 16'h7FFF) begin failures++; $display("FAIL fmul_satpos got=%h exp=7FFF", result); end
    checks++; if ({overflow, negative} !== 2'b10) begin failures++; $display("FAIL fmul_satpos_flags got=%b exp=10", {overflow, negative}); end

    run_op(2'b00, 16'h8100, 16'h0200);  // -127.0 * 2.0 -> negative saturation
    checks++; if (result !== 16'h8000) begin failures++; $display("FAIL fmul_satneg got=%h exp=8000", result); end
    checks++; if ({overflow, negative} !== 2'b11) begin failures++; $display("FAIL fmul_satneg_flags got=%b exp=11", {overflow, negative}); end

    run_op(2'b00, 16'hFFFF, 16'h0080);  // -1/256 * 0.5 = -1/512, floors to -1/256
    checks++; if (result !== 16'hFFFF) begin failures++; $display("FAIL fmul_floor got=%h exp=FFFF", result); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fmul_floor_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_unsigned_int_mul();
    run_op(2'b01, 16'hFFFF, 16'hFFFF);
    checks++; if (lat !== 17) begin failures++; $display("FAIL imul_latency got=%0d exp=17", lat); end
    checks++; if (result !== 16'h0001) begin failures++; $display("FAIL imul_result got=%h exp=0001", result); end
    checks++; if (aux !== 16'hFFFE) begin failures++; $display("FAIL imul_aux got=%h exp=FFFE", aux); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL imul_ovf got=%b exp=1", overflow); end

    run_op(2'b01, 16'h0000, 16'h1234);
    checks++; if ({result, aux} !== 32'h0000_0000) begin failures++; $display("FAIL imul_zero_val got=%h exp=00000000", {result, aux}); end
    checks++; if ({zero, overflow, negative} !== 3'b100) begin
      failures++; $display("FAIL imul_zero_flags got=%b exp=100", {zero, overflow, negative});
    end
  endtask

  task automatic test_unsigned_int_div();
    run_op(2'b11, 16'd100, 16'd7);
    checks++; if (lat !== 17) begin failures++; $display("FAIL idiv_latency got=%0d exp=17", lat); end
    checks++; if (result !== 16'd14) begin failures++; $display("FAIL idiv_result got=%0d exp=14", result); end
    checks++; if (aux !== 16'd2) begin failures++; $display("FAIL idiv_aux got=%0d exp=2", aux); end
    checks++; if ({overflow, divide_by_zero} !== 2'b00) begin failures++; $display("FAIL idiv_flags got=%b exp=00", {overflow, divide_by_zero}); end

    run_op(2'b11, 16'hFFFF, 16'h0001);
    checks++; if ({result, aux} !== 32'hFFFF_0000) begin failures++; $display("FAIL idiv_max got=%h exp=FFFF0000", {result, aux}); end
    checks++; if (negative !== 1'b1) begin failures++; $display("FAIL idiv_max_neg got=%b exp=1", negative); end
  endtask

  task automatic test_signed_fixed_div();
    run_op(2'b10, 16'h0100, 16'h0300);  // 1.0 / 3.0
    checks++; if (lat !== 25) begin failures++; $display("FAIL fdiv_latency got=%0d exp=25", lat); end
    checks++; if (busy_cycles !== 24) begin failures++; $display("FAIL fdiv_busy got=%0d exp=24", busy_cycles); end
    checks++; if (result !== 16'h0055) begin failures++; $display("FAIL fdiv_result got=%h exp=0055", result); end
    checks++; if (aux !== 16'h0000) begin failures++; $display("FAIL fdiv_aux got=%h exp=0000", aux); end

    run_op(2'b10, 16'hFF00, 16'h0300);  // -1.0 / 3.0, truncated toward zero
    checks++; if (result !== 16'hFFAB) begin failures++; $display("FAIL fdiv_neg got=%h exp=FFAB", result); end
    checks++; if ({negative, overflow} !== 2'b10) begin failures++; $display("FAIL fdiv_neg_flags got=%b exp=10", {negative, overflow}); end

    run_op(2'b10, 16'h7F00, 16'h0080);  // 127.0 / 0.5 -> saturate
    checks++; if ({overflow, result} !== {1'b1, 16'h7FFF}) begin
      failures++; $display("FAIL fdiv_satpos got=%b_%h exp=1_7FFF", overflow, result);
    end

    run_op(2'b10, 16'h8000, 16'h0100);  // -128.0 / 1.0 is exactly representable
    checks++; if ({overflow, result} !== {1'b0, 16'h8000}) begin
      failures++; $display("FAIL fdiv_minneg got=%b_%h exp=0_8000", overflow, result);
    end

    run_op(2'b10, 16'h8000, 16'hFF00);  // -128.0 / -1.0 = +128 does not fit
    checks++; if ({overflow, result} !== {1'b1, 16'h7FFF}) begin
      failures++; $display("FAIL fdiv_minneg_flip got=%b_%h exp=1_7FFF", overflow, result);
    end
  endtask

  task automatic test_divide_by_zero();
    run_op(2'b10, 16'hFF00, 16'h0000);
    checks++; if (lat !== 1) begin failures++; $display("FAIL dz_fdiv_latency got=%0d exp=1", lat); end
    checks++; if (busy_cycles !== 0) begin failures++; $display("FAIL dz_fdiv_busy got=%0d exp=0", busy_cycles); end
    checks++; if ({result, aux} !== 32'h8000_0000) begin failures++; $display("FAIL dz_fdiv_val got=%h exp=80000000", {result, aux}); end
    checks++; if ({divide_by_zero, overflow, negative} !== 3'b111) begin
      failures++; $display("FAIL dz_fdiv_flags got=%b exp=111", {divide_by_zero, overflow, negative});
    end

    run_op(2'b10, 16'h0100, 16'h0000);
    checks++; if (result !== 16'h7FFF) begin failures++; $display("FAIL dz_fdiv_pos got=%h exp=7FFF", result); end

    run_op(2'b11, 16'd5, 16'h0000);
    checks++; if (lat !== 1) begin failures++; $display("FAIL dz_idiv_latency got=%0d exp=1", lat); end
    checks++; if ({result, aux} !== 32'hFFFF_0005) begin failures++; $display("FAIL dz_idiv_val got=%h exp=FFFF0005", {result, aux}); end
    checks++; if ({divide_by_zero, overflow} !== 2'b11) begin failures++; $display("FAIL dz_idiv_flags got=%b exp=11", {divide_by_zero, overflow}); end

    run_op(2'b01, 16'd2, 16'd3);
    checks++; if ({divide_by_zero, result} !== {1'b0, 16'd6}) begin
      failures++; $display("FAIL dz_clear got=%b_%h exp=0_0006", divide_by_zero, result);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    operation = 2'b11;
    operand_a = 16'd100;
    operand_b = 16'd7;
    start     = 1'b1;
    @(posedge clock);
    #1;
    // start stays high; the next request is already presented while busy
    operation = 2'b01;
    operand_a = 16'd3;
    operand_b = 16'd5;
    wait_done();
    checks++; if (lat !== 17) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=17", lat); end
    checks++; if ({result, aux} !== {16'd14, 16'd2}) begin failures++; $display("FAIL b2b_first got=%h exp=000E0002", {result, aux}); end
    @(negedge clock);
    start = 1'b0;
    checks++; if ({busy, done} !== 2'b10) begin failures++; $display("FAIL b2b_no_gap got=%b exp=10", {busy, done}); end
    wait_done();
    checks++; if (lat + 1 !== 17) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=17", lat + 1); end
    checks++; if ({result, aux} !== {16'd15, 16'd0}) begin failures++; $display("FAIL b2b_second got=%h exp=000F0000", {result, aux}); end
  endtask

  task automatic test_ignore_busy();
    @(negedge clock);
    operation = 2'b00;
    operand_a = 16'h0200;  // 2.0
    operand_b = 16'h0300;  // 3.0
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      // a divide-by-zero would finish immediately if this start were taken
      operation = 2'b11;
      operand_a = 16'h0001;
      operand_b = 16'h0000;
      start     = 1'b1;
      checks++; if ({done, result} !== {1'b0, 16'h000F}) begin
        failures++; $display("FAIL busy_hold got=%b_%h exp=0_000F", done, result);
      end
      @(posedge clock);
      #1;
      start = 1'b0;
    end
    wait_done();
    checks++; if (lat + 4 !== 17) begin failures++; $display("FAIL busy_latency got=%0d exp=17", lat + 4); end
    checks++; if ({result, divide_by_zero, overflow} !== {16'h0600, 2'b00}) begin
      failures++; $display("FAIL busy_result got=%h_%b exp=0600_00", result, {divide_by_zero, overflow});
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clock);
    operation = 2'b00;
    operand_a = 16'h0180;
    operand_b = 16'hFE00;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL midreset_ctrl got=%b exp=00", {busy, done}); end
    checks++; if ({result, aux} !== 32'h0000_0000) begin failures++; $display("FAIL midreset_data got=%h exp=00000000", {result, aux}); end
    checks++; if ({overflow, divide_by_zero, zero, negative} !== 4'b0000) begin
      failures++; $display("FAIL midreset_flags got=%b exp=0000", {overflow, divide_by_zero, zero, negative});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if ({busy, done} !== 2'b00) begin failures++; $display("FAIL midreset_discard got=%b exp=00", {busy, done}); end
    run_op(2'b01, 16'd3, 16'd4);
    checks++; if (lat !== 17) begin failures++; $display("FAIL postreset_latency got=%0d exp=17", lat); end
    checks++; if ({result, aux} !== {16'd12, 16'd0}) begin failures++; $display("FAIL postreset_mul got=%h exp=000C0000", {result, aux}); end
  endtask

  initial begin
    test_reset();
    test_signed_fixed_mul();
    test_unsigned_int_mul();
    test_unsigned_int_div();
    test_signed_fixed_div();
    test_divide_by_zero();
    test_back_to_back();
    test_ignore_busy();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/fixed_point_muldiv_unit.md
Name: fixed_point_muldiv_unit

Overview:
- Parametrised iterative multiply/divide coprocessor; next generation of the datapath's single-cycle Q8.8 MULTIPLY.
- Adds division, unsigned integer modes, saturation and status flags.
- Sits beside the alu. The controller pulses start, waits for done, then writes result/aux to the register file through the extra write-data mux.
- One multicycle operation in flight at a time; operands are latched at start.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 8)
- FRAC_BITS, 8, fractional bits for fixed-point modes (0 < FRAC_BITS < WIDTH)

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when the unit is ready (IDLE or DONE)
- operation  input  2  00 signed fixed mul, 01 unsigned int mul, 10 signed fixed div, 11 unsigned int div
- operand_a  input  WIDTH  multiplicand / dividend
- operand_b  input  WIDTH  multiplier / divisor
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; result, aux and flags valid from this cycle
- result  output  WIDTH  product / quotient
- aux  output  WIDTH  upper product half (op 01), remainder (op 11), else 0
- overflow  output  1  result saturated or truncated
- divide_by_zero  output  1  divisor was 0
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]

Behaviour:
- Reset (asynchronous, active-low): state IDLE; busy, done, result, aux and all flags are 0; iteration counter is 0. Reset mid-operation discards the operation; nothing is written.
- State machine IDLE -> RUN -> DONE -> IDLE.
  - DONE lasts exactly one cycle with done=1.
  - start seen in DONE goes directly to RUN (back-to-back operations).
- Accept: on the clock edge where start=1 in IDLE or DONE, the unit latches operand_a, operand_b and operation.
  - busy=1 from the next cycle.
  - start while busy is ignored.
  - Operand inputs are don't-care after acceptance.
- Iteration count N:
  - WIDTH for ops 00, 01, 11.
  - WIDTH+FRAC_BITS for op 10.
  - Radix-2, one bit per cycle.
- Latency: done asserts N+1 cycles after the accepting edge; busy is high for those N cycles.
- Outputs hold their values from DONE until the next DONE; reset clears them.
- Op 00 (signed fixed mul):
  - Full 2*WIDTH signed product, arithmetic right shift by FRAC_BITS (floor), so results match the existing alu MULTIPLY.
  - If the shifted value does not fit signed WIDTH: saturate to 0x7FFF.. or 0x800.. and set overflow.
  - aux=0.
- Op 01 (unsigned int mul): result = product low half, aux = high half, overflow = (aux != 0).
- Op 10 (signed fixed div):
  - Restoring division on magnitudes of (|a| << FRAC_BITS) / |b|.
  - Quotient truncates toward zero; negated if the signs of a and b differ.
  - If the quotient does not fit signed WIDTH: saturate and set overflow.
  - aux=0.
- Op 11 (unsigned int div): result = a / b, aux = a % b.
- Divide by zero (ops 10, 11 with b==0):
  - No iteration; DONE on the cycle after accept (latency 1).
  - divide_by_zero=1, overflow=1.
  - Op 11: result all-ones, aux=a.
  - Op 10: result = max positive if a >= 0, min negative if a < 0; aux=0.
- Flags: zero and negative are computed from the final result. All flags update only at DONE.
- divide_by_zero=0 for mul operations.

Test Plan:
- Op 00, a=0x0180 (1.5), b=0xFE00 (-2.0) -> done exactly 17 cycles after accept; result=0xFD00, negative=1, overflow=0, aux=0; busy high for 16 cycles.
- Op 00, a=0x7F00, b=0x0200 -> result=0x7FFF, overflow=1. Op 01, a=0xFFFF, b=0xFFFF -> result=0x0001, aux=0xFFFE, overflow=1.
- Op 11, a=100, b=7 -> result=14, aux=2, latency 17. Op 10, a=0x0100, b=0x0300 -> result=0x0055, latency 25. Op 10, a=0xFF00, b=0x0300 -> result=0xFFAB, negative=1.
- Op 10, a=0xFF00, b=0 -> done 1 cycle after accept; result=0x8000, divide_by_zero=1, overflow=1. Op 11, a=5, b=0 -> result=0xFFFF, aux=5.
- Back-to-back: hold start high through DONE -> second operation accepted on the done cycle, no idle gap. start pulses and operand changes while busy -> ignored; result unchanged.
- Assert reset (low) at cycle 5 of a multiply -> busy, done, result and flags are 0 immediately, without waiting for a clock. After release, a new 3*4 op 01 -> result=12, aux=0.
